// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midi_pkg
// Description : Shared constants, state encoding and helpers for the MIDI
//               channel-voice message decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

  // Channel voice status high nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // System exclusive framing bytes
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  // Controller number reported after reset (sustain pedal)
  localparam logic [6:0] SUSTAIN_CC = 7'd64;

  // Parser state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } state_e;

  // Program change and channel pressure carry a single data byte
  function automatic logic two_data_bytes(input logic [3:0] nib);
    return !((nib == PROG) || (nib == CHAN_AT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_byte_classifier.sv
`default_nettype none
// ============================================================================
// Module      : midi_byte_classifier
// Description : Purely combinational classification of a received MIDI byte
//               into channel status / system common / realtime, plus the
//               data byte count implied by a channel status byte.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_byte_classifier
  import midi_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_status,
  output logic       is_realtime,
  output logic       is_common,
  output logic       needs_two_data
);

  // Decode byte class from the upper bits
  always_comb begin
    is_status      = byte_in[7] && (byte_in[7:4] != 4'hF);
    is_common      = (byte_in[7:3] == 5'b11110);
    is_realtime    = (byte_in[7:3] == 5'b11111);
    needs_two_data = two_data_bytes(byte_in[7:4]);
  end

endmodule
`default_nettype wire

// File: rtl/midi_msg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : midi_msg_decoder
// Description : Parses a raw MIDI byte stream into note and controller
//               events. Supports running status, channel filtering,
//               note-off normalisation and skipping of SysEx/realtime bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_decoder
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [13:0] note_values,
  output logic [13:0] controller_values,
  output logic        update_voice,
  output logic        update_all_voices,
  output logic        msg_dropped
);

  localparam logic [13:0] CTRL_RESET = {7'd0, SUSTAIN_CC};

  state_e      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic        two_data_q, two_data_d;
  logic [6:0]  d1_q, d1_d;
  logic [13:0] note_values_q, note_values_d;
  logic [13:0] controller_values_q, controller_values_d;
  logic        update_voice_q, update_voice_d;
  logic        update_all_q, update_all_d;
  logic        msg_dropped_q, msg_dropped_d;

  logic        is_status, is_realtime, is_common, needs_two_data;
  logic        chan_match;
  logic        msg_done;
  logic [6:0]  fin_d1, fin_d2;

  midi_byte_classifier u_classifier (
    .byte_in        (byte_in),
    .is_status      (is_status),
    .is_realtime    (is_realtime),
    .is_common      (is_common),
    .needs_two_data (needs_two_data)
  );

  assign chan_match = (OMNI != 0) || (status_q[3:0] == CHANNEL[3:0]);

  // Next-state, running-status tracking and event generation
  always_comb begin
    state_d             = state_q;
    status_d            = status_q;
    two_data_d          = two_data_q;
    d1_d                = d1_q;
    note_values_d       = note_values_q;
    controller_values_d = controller_values_q;
    update_voice_d      = 1'b0;
    update_all_d        = 1'b0;
    msg_dropped_d       = 1'b0;
    msg_done            = 1'b0;
    fin_d1              = 7'd0;
    fin_d2              = 7'd0;

    // Realtime bytes leave every piece of parser state untouched
    if (byte_valid && !is_realtime) begin
      if (is_status) begin
        // A new status abandons a message that already had its first data byte
        if (state_q == ST_WAIT_D2) begin
          msg_dropped_d = 1'b1;
        end
        status_d   = byte_in;
        two_data_d = needs_two_data;
        state_d    = ST_WAIT_D1;
      end else if (is_common) begin
        status_d   = 8'd0;
        two_data_d = 1'b0;
        state_d    = (byte_in == SYSEX_START) ? ST_SYSEX : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            msg_dropped_d = 1'b1;
          end
          ST_WAIT_D1: begin
            if (two_data_q) begin
              d1_d    = byte_in[6:0];
              state_d = ST_WAIT_D2;
            end else begin
              msg_done = 1'b1;
              fin_d1   = byte_in[6:0];
            end
          end
          ST_WAIT_D2: begin
            msg_done = 1'b1;
            fin_d1   = d1_q;
            fin_d2   = byte_in[6:0];
            state_d  = ST_WAIT_D1;
          end
          default: begin
            // SysEx payload is skipped
          end
        endcase
      end
    end

    // Only note and controller messages on our channel produce events
    if (msg_done && chan_match) begin
      case (status_q[7:4])
        NOTE_ON: begin
          note_values_d  = {fin_d2, fin_d1};
          update_voice_d = 1'b1;
        end
        NOTE_OFF: begin
          note_values_d  = {7'd0, fin_d1};
          update_voice_d = 1'b1;
        end
        CTRL: begin
          controller_values_d = {fin_d2, fin_d1};
          update_voice_d      = 1'b1;
          update_all_d        = 1'b1;
        end
        default: begin
          // Aftertouch, program change and pitch bend are consumed silently
        end
      endcase
    end
  end

  // Parser and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      status_q            <= 8'd0;
      two_data_q          <= 1'b0;
      d1_q                <= 7'd0;
      note_values_q       <= 14'd0;
      controller_values_q <= CTRL_RESET;
      update_voice_q      <= 1'b0;
      update_all_q        <= 1'b0;
      msg_dropped_q       <= 1'b0;
    end else begin
      state_q             <= state_d;
      status_q            <= status_d;
      two_data_q          <= two_data_d;
      d1_q                <= d1_d;
      note_values_q       <= note_values_d;
      controller_values_q <= controller_values_d;
      update_voice_q      <= update_voice_d;
      update_all_q        <= update_all_d;
      msg_dropped_q       <= msg_dropped_d;
    end
  end

  assign note_values       = note_values_q;
  assign controller_values = controller_values_q;
  assign update_voice      = update_voice_q;
  assign update_all_voices = update_all_q;
  assign msg_dropped       = msg_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_msg_decoder
// Description : Self-checking bench for midi_msg_decoder. Two instances
//               (channel 0 filtered, and omni) are compared every cycle
//               against a byte-level message model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_msg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;

  logic [13:0] nv [2];
  logic [13:0] cv [2];
  logic        uv [2];
  logic        ua [2];
  logic        md [2];

  always #5 clk = ~clk;

  midi_msg_decoder #(.CHANNEL(0), .OMNI(0)) u_dut0 (
    .clk(clk), .reset(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .note_values(nv[0]), .controller_values(cv[0]),
    .update_voice(uv[0]), .update_all_voices(ua[0]), .msg_dropped(md[0])
  );

  midi_msg_decoder #(.CHANNEL(3), .OMNI(1)) u_dut1 (
    .clk(clk), .reset(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .note_values(nv[1]), .controller_values(cv[1]),
    .update_voice(uv[1]), .update_all_voices(ua[1]), .msg_dropped(md[1])
  );

  // Model configuration per instance
  int m_ch   [2] = '{0, 3};
  bit m_omni [2] = '{1'b0, 1'b1};

  // Model state: running status (-1 = none), in-SysEx flag, collected data
  int rs   [2];
  bit sx   [2];
  int nd   [2];
  int dbuf [2][2];

  // Values the outputs take after the next clock edge
  logic [13:0] p_note [2];
  logic [13:0] p_ctrl [2];
  bit          p_uv [2];
  bit          p_ua [2];
  bit          p_md [2];

  // Values the outputs must currently show
  logic [13:0] e_note [2] = '{14'd0, 14'd0};
  logic [13:0] e_ctrl [2] = '{14'd64, 14'd64};
  bit          e_uv [2] = '{1'b0, 1'b0};
  bit          e_ua [2] = '{1'b0, 1'b0};
  bit          e_md [2] = '{1'b0, 1'b0};

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    rs[k] = -1; sx[k] = 1'b0; nd[k] = 0;
    p_note[k] = 14'd0; p_ctrl[k] = 14'd64;
    p_uv[k] = 1'b0; p_ua[k] = 1'b0; p_md[k] = 1'b0;
  endtask

  task automatic model_byte(input int k, input int b);
    int hi;
    int need;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      rs[k] = -1; sx[k] = (b == 'hF0); nd[k] = 0;
      return;
    end
    if (b >= 'h80) begin
      if (nd[k] == 1) p_md[k] = 1'b1;
      rs[k] = b; sx[k] = 1'b0; nd[k] = 0;
      return;
    end
    if (sx[k]) return;
    if (rs[k] < 0) begin
      p_md[k] = 1'b1;
      return;
    end
    dbuf[k][nd[k]] = b;
    nd[k]++;
    hi   = rs[k] >> 4;
    need = (hi == 12 || hi == 13) ? 1 : 2;
    if (nd[k] < need) return;
    nd[k] = 0;
    if (!m_omni[k] && ((rs[k] & 15) != m_ch[k])) return;
    case (hi)
      9:  begin p_note[k] = 14'(dbuf[k][1] * 128 + dbuf[k][0]); p_uv[k] = 1'b1; end
      8:  begin p_note[k] = 14'(dbuf[k][0]); p_uv[k] = 1'b1; end
      11: begin p_ctrl[k] = 14'(dbuf[k][1] * 128 + dbuf[k][0]); p_uv[k] = 1'b1; p_ua[k] = 1'b1; end
      default: ;
    endcase
  endtask

  // Advance expected outputs with the DUT clock
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e_note[k] <= 14'd0; e_ctrl[k] <= 14'd64;
        e_uv[k] <= 1'b0; e_ua[k] <= 1'b0; e_md[k] <= 1'b0;
      end else begin
        e_note[k] <= p_note[k]; e_ctrl[k] <= p_ctrl[k];
        e_uv[k] <= p_uv[k]; e_ua[k] <= p_ua[k]; e_md[k] <= p_md[k];
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("note_values", k, 32'(nv[k]), 32'(e_note[k]));
      chk("controller_values", k, 32'(cv[k]), 32'(e_ctrl[k]));
      chk("update_voice", k, 32'(uv[k]), 32'(e_uv[k]));
      chk("update_all_voices", k, 32'(ua[k]), 32'(e_ua[k]));
      chk("msg_dropped", k, 32'(md[k]), 32'(e_md[k]));
    end
  end

  task automatic send(input logic [7:0] b, input bit v);
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      p_uv[k] = 1'b0; p_ua[k] = 1'b0; p_md[k] = 1'b0;
    end
    byte_in    = b;
    byte_valid = v;
    if (v) begin
      for (int k = 0; k < 2; k++) model_byte(k, int'(b));
    end
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send(s[i], 1'b1);
  endtask

  // Reset pulse held across one edge, optionally with a byte strobe colliding
  task automatic do_reset(input bit with_byte);
    @(posedge clk);
    #2;
    byte_in    = 8'h3C;
    byte_valid = with_byte;
    rst        = 1'b1;
    for (int k = 0; k < 2; k++) model_reset(k);
    @(posedge clk);
    #2;
    byte_valid = 1'b0;
    rst        = 1'b0;
  endtask

  // One idle cycle, then park on the falling edge where outputs are stable
  task automatic settle();
    send(8'h00, 1'b0);
    #3;
  endtask

  initial begin
    int r;
    logic [3:0] hi;
    logic [3:0] ch;
    logic [7:0] b;

    for (int k = 0; k < 2; k++) model_reset(k);
    repeat (2) @(posedge clk);
    #3;
    chk("lit_reset_note", 0, 32'(nv[0]), 32'h0);
    chk("lit_reset_ctrl", 0, 32'(cv[0]), 32'h40);
    rst = 1'b0;

    send_seq('{8'h90, 8'h1D, 8'h7F});
    settle();
    chk("lit_note_on", 0, 32'(nv[0]), 32'h3F9D);
    chk("lit_note_on_uv", 0, 32'(uv[0]), 32'h1);
    chk("lit_note_on_ua", 0, 32'(ua[0]), 32'h0);

    send_seq('{8'h1D, 8'h00});
    settle();
    chk("lit_running_vel0", 0, 32'(nv[0]), 32'd29);
    chk("lit_running_uv", 0, 32'(uv[0]), 32'h1);

    send_seq('{8'hB0, 8'h40, 8'h7F});
    settle();
    chk("lit_cc", 0, 32'(cv[0]), 32'h3FC0);
    chk("lit_cc_uv", 0, 32'(uv[0]), 32'h1);
    chk("lit_cc_ua", 0, 32'(ua[0]), 32'h1);

    send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64});
    settle();
    chk("lit_realtime_mid", 0, 32'(nv[0]), 32'h323C);
    send_seq('{8'h91, 8'h3C, 8'h64});
    settle();
    chk("lit_other_chan_note", 0, 32'(nv[0]), 32'h323C);
    chk("lit_other_chan_uv", 0, 32'(uv[0]), 32'h0);
    chk("lit_omni_uv", 1, 32'(uv[1]), 32'h1);

    send_seq('{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h40});
    settle();
    chk("lit_orphan_drop", 0, 32'(md[0]), 32'h1);
    send_seq('{8'h80, 8'h3C, 8'h40});
    settle();
    chk("lit_note_off", 0, 32'(nv[0]), 32'd60);

    send_seq('{8'h90, 8'h3C, 8'h90});
    settle();
    chk("lit_partial_drop", 0, 32'(md[0]), 32'h1);
    send_seq('{8'h3C, 8'h40});

    send_seq('{8'h90, 8'h3C});
    do_reset(1'b1);
    settle();
    chk("lit_midreset_note", 0, 32'(nv[0]), 32'h0);
    chk("lit_midreset_ctrl", 0, 32'(cv[0]), 32'd64);
    send(8'h3C, 1'b1);
    settle();
    chk("lit_after_reset_drop1", 0, 32'(md[0]), 32'h1);
    send(8'h40, 1'b1);
    settle();
    chk("lit_after_reset_drop2", 0, 32'(md[0]), 32'h1);
    chk("lit_after_reset_uv", 0, 32'(uv[0]), 32'h0);

    // Randomised byte stream, mostly back-to-back
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        send(8'h00, 1'b0);
      end else if (r == 4) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        if (r < 50) begin
          b = 8'($urandom_range(0, 127));
        end else if (r < 78) begin
          hi = 4'($urandom_range(8, 14));
          case ($urandom_range(0, 2))
            0:       ch = 4'd0;
            1:       ch = 4'd3;
            default: ch = 4'($urandom_range(0, 15));
          endcase
          b = {hi, ch};
        end else if (r < 86) begin
          b = 8'($urandom_range(8'hF8, 8'hFF));
        end else if (r < 94) begin
          case ($urandom_range(0, 2))
            0:       b = 8'hF0;
            1:       b = 8'hF7;
            default: b = 8'($urandom_range(8'hF1, 8'hF6));
          endcase
        end else begin
          b = 8'($urandom_range(0, 127));
        end
        send(b, 1'b1);
      end
    end

    repeat (3) send(8'h00, 1'b0);
    #3;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/midi_msg_decoder.md
Name: midi_msg_decoder

Overview:
- Upstream neighbour of midi_harmonic_dynamics. Consumes raw MIDI bytes from the UART receiver and parses channel voice messages.
- Produces the note_values/controller_values words plus update_voice/update_all_voices strobes that the dynamics stage latches.
- Handles running status, channel filtering, note-off normalisation, and skipping of system/realtime traffic.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 0, 1 = accept all 16 channels.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_in  in  8  received MIDI byte; valid only when byte_valid=1
- byte_valid  in  1  one-cycle strobe, one per received byte
- note_values  out  14  {velocity[13:7], note[6:0]}
- controller_values  out  14  {ctrl_value[13:7], ctrl_number[6:0]}
- update_voice  out  1  one-cycle strobe: new note or controller event
- update_all_voices  out  1  one-cycle strobe: controller event applies to all voices
- msg_dropped  out  1  one-cycle strobe: partial or orphan message discarded

Behaviour:
- Reset (async, immediate): state=IDLE, running status cleared. note_values=0, controller_values={7'd0,7'd64}, all strobes 0. Reset wins over a simultaneous byte_valid.
- Byte classes:
  - status: bit7=1 and <0xF0
  - system common: 0xF0-0xF7
  - realtime: 0xF8-0xFF
  - data: bit7=0
- Realtime bytes are ignored entirely. State, running status and partial data are untouched.
- States:
  - IDLE: no running status. A data byte here is discarded with msg_dropped=1.
  - WAIT_D1: status held, expecting first data byte.
  - WAIT_D2: first data byte held, expecting second.
  - SYSEX: entered on 0xF0. All data bytes are ignored until 0xF7 or any status byte.
- Channel status byte:
  - Latch as running status, go to WAIT_D1.
  - If the previous state was WAIT_D2, pulse msg_dropped (a partial message was abandoned).
- System common byte: clears running status.
  - 0xF0 -> SYSEX.
  - Any other 0xF1-0xF7 -> IDLE. Their data bytes then fall into IDLE and are dropped; this is accepted behaviour.
- Data byte counts by status high nibble:
  - 0xC (program change), 0xD (channel pressure): one data byte, then message complete.
  - 0x8, 0x9, 0xA, 0xB, 0xE: two data bytes.
- On message complete, return to WAIT_D1 (running status retained).
- Channel mismatch (OMNI=0, status[3:0]!=CHANNEL): bytes are consumed normally, no output effect, no msg_dropped.
- Actions on a complete, matching message:
  - 0x9 note-on: note_values={d2,d1}, update_voice=1. Velocity 0 is passed through as 0, which means note-off downstream.
  - 0x8 note-off: note_values={7'd0,d1}, update_voice=1. Release velocity is discarded.
  - 0xB control change: controller_values={d2,d1}, update_voice=1 and update_all_voices=1 in the same cycle.
  - 0xA, 0xC, 0xD, 0xE: consumed silently.
- Latency: output registers update and strobes assert on the clock edge that samples the final data byte's byte_valid. Strobes are high for exactly one cycle.
- note_values and controller_values hold between events. Back-to-back byte_valid on consecutive cycles must be supported.
- Reset mid-message: partial message lost, no strobe emitted.

Decomposition:
- Shared package midi_pkg:
  - status nibble constants NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CTRL=4'hB, PROG=4'hC, CHAN_AT=4'hD, PITCH=4'hE
  - SYSEX_START=8'hF0, SYSEX_END=8'hF7
  - SUSTAIN_CC=7'd64
  - state encoding constants
- Sub-module midi_byte_classifier: combinational byte -> {is_status, is_realtime, is_common, needs_two_data}. Keeps the FSM free of decode logic.

Test Plan:
- Bytes 0x90,0x1D,0x7F (CHANNEL=0) -> one cycle after last byte: note_values=14'h3F9D, update_voice=1 for 1 cycle, update_all_voices=0.
- Running status: 0x90,0x1D,0x7F,0x1D,0x00 -> two update_voice pulses; final note_values={7'd0,7'd29}.
- 0xB0,0x40,0x7F -> controller_values={7'h7F,7'h40}, update_voice and update_all_voices both high the same cycle.
- 0x90,0x3C,0xF8,0x64 (realtime mid-message) -> note_values={7'd100,7'd60}, single pulse. Then 0x91,0x3C,0x64 with OMNI=0 -> no pulse, outputs unchanged.
- 0xF0,0x12,0x34,0xF7,0x40 -> no strobes from SysEx; msg_dropped pulses on 0x40 (IDLE). Then 0x80,0x3C,0x40 -> note_values={7'd0,7'd60}.
- Sequence 0x90,0x3C followed by reset pulse, then 0x3C,0x40 -> no update_voice; outputs at reset values; msg_dropped pulses twice.
